// File: rtl/radix8_seq_mul.sv
// Sequential 8x8 unsigned radix-8 multiplier: one 3-bit digit of B per cycle selects a
// precomputed multiple of A, which is shifted and accumulated into a 16-bit product.
module radix8_seq_mul #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DIGIT_WIDTH = 3,
  parameter int unsigned SEL_WIDTH   = 7,
  parameter int unsigned NUM_DIGITS  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    iValid,
  output logic                    oReady,
  input  logic [DATA_WIDTH-1:0]   iA,
  input  logic [DATA_WIDTH-1:0]   iB,
  output logic                    oValid,
  input  logic                    iReady,
  output logic [2*DATA_WIDTH-1:0] oProd,
  output logic                    oBusy
);

  localparam int unsigned MultW = DATA_WIDTH + DIGIT_WIDTH;
  localparam int unsigned ProdW = 2 * DATA_WIDTH;
  localparam int unsigned BPadW = NUM_DIGITS * DIGIT_WIDTH;
  localparam int unsigned CntW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  typedef enum logic [1:0] {StIdle, StPre, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d;
  logic [BPadW-1:0]     b_q, b_d;
  logic [ProdW-1:0]     acc_q, acc_d;
  logic [ProdW-1:0]     prod_q, prod_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [MultW-1:0]     m3_q, m3_d, m5_q, m5_d, m6_q, m6_d, m7_q, m7_d;

  logic [MultW-1:0]       m1, m2, m4, m8;
  logic [4:0]             shamt;
  logic [DIGIT_WIDTH-1:0] digit;
  logic [SEL_WIDTH-1:0]   booth_sel;
  logic [MultW-1:0]       mult;

  // A, 2A, 4A and 8A are pure wiring; the odd/compound multiples are registered in PRE.
  assign m1 = MultW'(a_q);
  assign m2 = m1 << 1;
  assign m4 = m1 << 2;
  assign m8 = m1 << 3;

  assign shamt = 5'(cnt_q) * 5'(DIGIT_WIDTH);
  assign digit = b_q[shamt +: DIGIT_WIDTH];

  // Digit encode: value k in 1..7 raises bit k-1, zero gives an all-zero select.
  always_comb begin
    booth_sel = '0;
    if (digit != '0) begin
      booth_sel = SEL_WIDTH'(1) << (digit - DIGIT_WIDTH'(1));
    end
  end

  // Anything that is not a clean one-hot select contributes nothing.
  always_comb begin
    mult = '0;
    case (booth_sel)
      7'b000_0001: mult = m1;
      7'b000_0010: mult = m2;
      7'b000_0100: mult = m3_q;
      7'b000_1000: mult = m4;
      7'b001_0000: mult = m5_q;
      7'b010_0000: mult = m6_q;
      7'b100_0000: mult = m7_q;
      default:     mult = '0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    prod_d  = prod_q;
    cnt_d   = cnt_q;
    m3_d    = m3_q;
    m5_d    = m5_q;
    m6_d    = m6_q;
    m7_d    = m7_q;
    unique case (state_q)
      StIdle: begin
        if (iValid) begin
          a_d     = iA;
          b_d     = BPadW'(iB);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = StPre;
        end
      end
      StPre: begin
        m3_d    = m1 + m2;
        m5_d    = m1 + m4;
        m6_d    = m2 + m4;
        m7_d    = m8 - m1;
        state_d = StRun;
      end
      StRun: begin
        acc_d = acc_q + (ProdW'(mult) << shamt);
        if (cnt_q == CntW'(NUM_DIGITS - 1)) begin
          prod_d  = acc_d;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StDone: begin
        if (iReady) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      prod_q  <= '0;
      cnt_q   <= '0;
      m3_q    <= '0;
      m5_q    <= '0;
      m6_q    <= '0;
      m7_q    <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      prod_q  <= prod_d;
      cnt_q   <= cnt_d;
      m3_q    <= m3_d;
      m5_q    <= m5_d;
      m6_q    <= m6_d;
      m7_q    <= m7_d;
    end
  end

  assign oReady = (state_q == StIdle);
  assign oValid = (state_q == StDone);
  assign oBusy  = (state_q != StIdle);
  assign oProd  = prod_q;

endmodule
